// File: rtl/vga_rx_pkg.sv
// Shared types and default 640x480 timing for the VGA receive-side timing monitor.
package vga_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BP_DEF        = 48;
  localparam int unsigned H_ACT_DEF       = 640;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BP_DEF        = 33;
  localparam int unsigned V_ACT_DEF       = 480;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned GOOD_W = 4;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// CRC-16-CCITT accumulator consuming one 12-bit pixel (MSB first) per enabled clock.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             init_i,
  input  logic             en_i,
  input  logic [RGB_W-1:0] data_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                input logic [RGB_W-1:0] d);
    logic [CRC_W-1:0] r;
    r = c;
    for (int i = int'(RGB_W) - 1; i >= 0; i--) begin
      r = {r[CRC_W-2:0], 1'b0} ^ (((r[CRC_W-1] ^ d[i]) == 1'b1) ? CRC_POLY : '0);
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc_step(crc_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) crc_q <= CRC_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/vga_timing_rx.sv
// Samples hs/vs/rgb on pix_ce, recovers coordinates, checks line/frame geometry, emits locked pixels.
// Define VGA_TIMING_RX_CRC_EN to add a per-frame CRC-16 of the active pixels.
module vga_timing_rx
  import vga_rx_pkg::*;
#(
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pix_ce,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             de,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [RGB_W-1:0] pixel,
  output logic             frame_start,
  output logic             locked,
  output logic             err,
  output logic [CRC_W-1:0] frame_crc,
  output logic             crc_valid
);

  localparam int unsigned H_ACT0 = H_SYNC + H_BP;
  localparam int unsigned V_ACT0 = V_SYNC + V_BP;

  logic             samp_v_q, samp_v_d, hs_s_q, hs_s_d, hs_p_q, hs_p_d, vs_s_q, vs_s_d;
  logic [RGB_W-1:0] rgb_s_q, rgb_s_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic             vs_line_q, vs_line_d;
  logic [GOOD_W-1:0] good_q, good_d;
  rx_state_e        state_q, state_d;
  logic             hs_fall, fs, viol;

  logic             de_q, de_d, fs_q, fs_d, locked_q, locked_d, err_q, err_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [RGB_W-1:0] pixel_q, pixel_d;
  logic [CRC_W-1:0] frame_crc_q, frame_crc_d;
  logic             crc_valid_q, crc_valid_d;

  // Stage 1: capture the stream; sync regs idle high so reset never fakes a frame start.
  always_comb begin
    samp_v_d = pix_ce;
    hs_s_d   = pix_ce ? hs_in  : hs_s_q;
    hs_p_d   = pix_ce ? hs_s_q : hs_p_q;
    vs_s_d   = pix_ce ? vs_in  : vs_s_q;
    rgb_s_d  = pix_ce ? rgb_in : rgb_s_q;
  end

  // Edge detection, coordinate counters and geometry checks on the registered sample.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vs_line_d = vs_line_q;
    hs_fall   = 1'b0;
    fs        = 1'b0;
    viol      = 1'b0;
    if (samp_v_q) begin
      hs_fall = hs_p_q & ~hs_s_q;
      if (hs_fall) begin
        fs        = vs_line_q & ~vs_s_q;
        hcnt_d    = '0;
        vcnt_d    = fs ? '0 : sat_inc(vcnt_q);
        vs_line_d = vs_s_q;
        if (state_q != SEARCH) begin
          viol = (32'(hcnt_q) + 32'd1 != H_TOTAL) ||
                 (fs && (32'(vcnt_q) + 32'd1 != V_TOTAL));
        end
      end else begin
        hcnt_d = sat_inc(hcnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // Lock FSM: a violation always drops back to SEARCH, even on a frame start.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (viol) begin
      state_d = SEARCH;
      good_d  = '0;
    end else if (fs) begin
      case (state_q)
        SEARCH: begin
          state_d = TRACK;
          good_d  = '0;
        end
        TRACK: begin
          good_d = good_q + GOOD_W'(1);
          if (32'(good_q) + 32'd1 >= LOCK_FRAMES) state_d = LOCKED;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    de_d     = 1'b0;
    col_d    = '0;
    row_d    = '0;
    pixel_d  = '0;
    fs_d     = 1'b0;
    err_d    = 1'b0;
    locked_d = (state_d == LOCKED);
    if (samp_v_q) begin
      fs_d  = fs;
      err_d = viol;
      if (state_d == LOCKED &&
          32'(hcnt_d) >= H_ACT0 && 32'(hcnt_d) < H_ACT0 + H_ACT &&
          32'(vcnt_d) >= V_ACT0 && 32'(vcnt_d) < V_ACT0 + V_ACT) begin
        de_d    = 1'b1;
        col_d   = COL_W'(32'(hcnt_d) - H_ACT0);
        row_d   = ROW_W'(32'(vcnt_d) - V_ACT0);
        pixel_d = rgb_s_q;
      end
    end
  end

`ifdef VGA_TIMING_RX_CRC_EN
  logic [CRC_W-1:0] crc_acc;
  logic             crc_init;

  assign crc_init = fs || (state_q == LOCKED && state_d != LOCKED);

  vga_rx_crc16 u_crc (
    .clk    (clk),
    .rstn   (rstn),
    .init_i (crc_init),
    .en_i   (de_d),
    .data_i (rgb_s_q),
    .crc_o  (crc_acc)
  );

  // Publish only frames that were fully locked and ended cleanly.
  always_comb begin
    crc_valid_d = fs && (state_q == LOCKED) && !viol;
    frame_crc_d = crc_valid_d ? crc_acc : frame_crc_q;
  end
`else
  always_comb begin
    crc_valid_d = 1'b0;
    frame_crc_d = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      samp_v_q    <= 1'b0;
      hs_s_q      <= 1'b1;
      hs_p_q      <= 1'b1;
      vs_s_q      <= 1'b1;
      rgb_s_q     <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      vs_line_q   <= 1'b1;
      good_q      <= '0;
      de_q        <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      pixel_q     <= '0;
      fs_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      frame_crc_q <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      samp_v_q    <= samp_v_d;
      hs_s_q      <= hs_s_d;
      hs_p_q      <= hs_p_d;
      vs_s_q      <= vs_s_d;
      rgb_s_q     <= rgb_s_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      vs_line_q   <= vs_line_d;
      good_q      <= good_d;
      de_q        <= de_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pixel_q     <= pixel_d;
      fs_q        <= fs_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      frame_crc_q <= frame_crc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign de          = de_q;
  assign col         = col_q;
  assign row         = row_q;
  assign pixel       = pixel_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign frame_crc   = frame_crc_q;
  assign crc_valid   = crc_valid_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a reduced 20x12 geometry with random pixels and pix_ce gaps.
module tb_vga_timing_rx;

  localparam int HT = 20, HS = 3, HB = 2, HA = 12;
  localparam int VT = 12, VS = 2, VB = 2, VA = 6;
  localparam int LK = 2;

  logic        clk = 1'b0, rstn = 1'b0, pix_ce = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
  logic [11:0] rgb_in = '0;
  logic        de, frame_start, locked, err, crc_valid;
  logic [9:0]  col;
  logic [8:0]  row;
  logic [11:0] pixel;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_timing_rx #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .LOCK_FRAMES(LK)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_ce(pix_ce), .hs_in(hs_in), .vs_in(vs_in), .rgb_in(rgb_in),
    .de(de), .col(col), .row(row), .pixel(pixel), .frame_start(frame_start),
    .locked(locked), .err(err), .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  typedef struct packed {
    logic        de;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [11:0] pixel;
    logic        fs;
    logic        locked;
    logic        err;
    logic [15:0] crc;
    logic        cv;
  } obs_t;

  int   checks = 0, errors = 0;
  obs_t exp_q = '0, got;

  // Reference model state: position since last hs fall, line count, lock progress.
  int          m_h, m_v, m_good;
  bit          m_hsp, m_vsl, m_track, m_lock;
  logic [15:0] m_acc, m_fcrc;

  int          gap_lo = 3, gap_hi = 3;
  bit          rgb_rand = 1'b1;
  logic [11:0] rgb_const = '0;
  int          obs_de, obs_err, obs_cv, first_col, first_row, last_col, last_row;
  bit          seen_de, saw_fs_err;

  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if ((r[15] ^ d[i]) == 1'b1) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                        r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc_frame(input logic [11:0] v);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 0; i < HA * VA; i++) r = crc12(r, v);
    return r;
  endfunction

  function automatic void model_reset();
    m_h = 0; m_v = 0; m_good = 0;
    m_hsp = 1'b1; m_vsl = 1'b1; m_track = 1'b0; m_lock = 1'b0;
    m_acc = 16'hFFFF; m_fcrc = '0;
    exp_q = '0;
  endfunction

  function automatic void model_sample(input bit hs, input bit vs, input logic [11:0] rgb);
    bit fall, fs, viol, act;
    fall = !hs && m_hsp;
    fs = 1'b0;
    viol = 1'b0;
    if (fall) begin
      fs = m_vsl && !vs;
      if (m_track || m_lock) viol = (m_h + 1 != HT) || (fs && (m_v + 1 != VT));
      m_h = 0;
      m_v = fs ? 0 : ((m_v < 1023) ? m_v + 1 : 1023);
      m_vsl = vs;
    end else if (m_h < 1023) begin
      m_h++;
    end
    m_hsp = hs;
    exp_q.fs  = fs;
    exp_q.err = viol;
`ifdef VGA_TIMING_RX_CRC_EN
    if (fs && m_lock && !viol) begin
      m_fcrc   = m_acc;
      exp_q.cv = 1'b1;
    end
`endif
    if (viol) begin
      m_track = 1'b0; m_lock = 1'b0; m_good = 0; m_acc = 16'hFFFF;
    end else if (fs) begin
      if (!m_track && !m_lock) begin
        m_track = 1'b1; m_good = 0;
      end else if (m_track) begin
        m_good++;
        if (m_good >= LK) begin m_track = 1'b0; m_lock = 1'b1; end
      end
    end
    if (fs) m_acc = 16'hFFFF;
    act = m_lock && m_h >= HS + HB && m_h < HS + HB + HA && m_v >= VS + VB && m_v < VS + VB + VA;
    if (act) begin
      exp_q.de    = 1'b1;
      exp_q.col   = 10'(m_h - (HS + HB));
      exp_q.row   = 9'(m_v - (VS + VB));
      exp_q.pixel = rgb;
      m_acc = crc12(m_acc, rgb);
    end
    exp_q.locked = m_lock;
    exp_q.crc    = m_fcrc;
  endfunction

  task automatic check_int(input string tag, input int g, input int e);
    checks++;
    assert (g === e) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, g, e);
    end
  endtask

  // One clock: drive on negedge, compare previous cycle's prediction after the edge.
  task automatic tick(input bit ce, input bit hs, input bit vs, input logic [11:0] rgb);
    @(negedge clk);
    pix_ce = ce; hs_in = hs; vs_in = vs; rgb_in = rgb;
    @(posedge clk);
    #1;
    got = {de, col, row, pixel, frame_start, locked, err, frame_crc, crc_valid};
    checks++;
    assert (got === exp_q) else begin
      errors++;
      $error("FAIL stream t=%0t got %h exp %h", $time, got, exp_q);
    end
    if (de) begin
      obs_de++;
      if (!seen_de) begin first_col = int'(col); first_row = int'(row); seen_de = 1'b1; end
      last_col = int'(col); last_row = int'(row);
    end
    if (err) obs_err++;
    if (crc_valid) obs_cv++;
    if (frame_start && err) saw_fs_err = 1'b1;
    exp_q.de = 1'b0; exp_q.col = '0; exp_q.row = '0; exp_q.pixel = '0;
    exp_q.fs = 1'b0; exp_q.err = 1'b0; exp_q.cv = 1'b0;
    if (ce) model_sample(hs, vs, rgb);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; pix_ce = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    assert ({de, col, row, pixel, frame_start, locked, err, frame_crc, crc_valid} === '0) else begin
      errors++;
      $error("FAIL reset got %h exp 0", {de, col, row, pixel, frame_start, locked, err, frame_crc, crc_valid});
    end
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic send_line(input int l, input int len);
    for (int p = 0; p < len; p++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) tick(1'b0, 1'($urandom), 1'($urandom), 12'($urandom));
      tick(1'b1, !(p < HS), !(l < VS), rgb_rand ? 12'($urandom) : rgb_const);
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len, input int exp_de);
    obs_de = 0; obs_err = 0; obs_cv = 0; seen_de = 1'b0;
    for (int l = 0; l < nlines; l++) send_line(l, (l == bad_line) ? bad_len : HT);
    if (exp_de >= 0) check_int("de_count", obs_de, exp_de);
    if (exp_de > 0) begin
      check_int("first_col", first_col, 0);
      check_int("first_row", first_row, 0);
      check_int("last_col", last_col, HA - 1);
      check_int("last_row", last_row, VA - 1);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // Sparse pix_ce (every 4th clk), joining mid-frame.
    gap_lo = 3; gap_hi = 3;
    for (int l = 5; l < VT; l++) send_line(l, HT);
    send_frame(VT, -1, 0, 0);
    check_int("locked_f1", int'(locked), 0);
    send_frame(VT, -1, 0, 0);
    check_int("locked_f2", int'(locked), 0);
    send_frame(VT, -1, 0, HA * VA);
    check_int("locked_f3", int'(locked), 1);

    // Continuous pix_ce must give identical counts and coordinates.
    gap_lo = 0; gap_hi = 0;
    send_frame(VT, -1, 0, HA * VA);
    send_frame(VT, -1, 0, HA * VA);

`ifdef VGA_TIMING_RX_CRC_EN
    gap_lo = 0; gap_hi = 2;
    rgb_rand = 1'b0; rgb_const = 12'hABC;
    send_frame(VT, -1, 0, HA * VA);
    send_frame(VT, -1, 0, HA * VA);
    check_int("crc_abc_1", int'(frame_crc), int'(crc_frame(12'hABC)));
    check_int("crc_valid_cnt", obs_cv, 1);
    send_frame(VT, -1, 0, HA * VA);
    check_int("crc_abc_2", int'(frame_crc), int'(crc_frame(12'hABC)));
    rgb_const = 12'h000;
    send_frame(VT, -1, 0, HA * VA);
    send_frame(VT, -1, 0, HA * VA);
    check_int("crc_000", int'(frame_crc), int'(crc_frame(12'h000)));
    rgb_rand = 1'b1;
`endif

    // One short line while locked.
    gap_lo = 0; gap_hi = 3;
    send_frame(VT, 7, HT - 1, -1);
    check_int("bad_line_err", obs_err, 1);
    check_int("bad_line_locked", int'(locked), 0);
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_int("relock_pending", int'(locked), 0);
    send_frame(VT, -1, 0, HA * VA);
    check_int("relock_line", int'(locked), 1);

    // Frame one line short: error lands on the frame start.
    saw_fs_err = 1'b0;
    send_frame(VT - 1, -1, 0, HA * VA);
    send_frame(VT, -1, 0, 0);
    check_int("short_fs_err", int'(saw_fs_err), 1);
    check_int("short_err_cnt", obs_err, 1);
    check_int("short_locked", int'(locked), 0);
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_int("short_no_gain", int'(locked), 0);
    send_frame(VT, -1, 0, HA * VA);
    check_int("relock_frame", int'(locked), 1);

    // Reset mid-line while locked, then full relock.
    for (int l = 0; l < 7; l++) send_line(l, HT);
    send_line(7, 8);
    do_reset();
    obs_de = 0;
    for (int l = 8; l < VT; l++) send_line(l, HT);
    send_frame(VT, -1, 0, 0);
    send_frame(VT, -1, 0, 0);
    check_int("rst_no_lock", int'(locked), 0);
    send_frame(VT, -1, 0, HA * VA);
    check_int("rst_relock", int'(locked), 1);
    tick(1'b0, 1'b1, 1'b1, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
